// File: rtl/alu_op_sequencer_pkg.sv
// Shared types and constants for the ALU operand sequencer and its companion ALU.
package alu_op_sequencer_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } seq_state_t;

    localparam logic [1:0] SEL_0 = 2'b00;
    localparam logic [1:0] SEL_1 = 2'b01;
    localparam logic [1:0] SEL_2 = 2'b10;
    localparam logic [1:0] SEL_3 = 2'b11;

endpackage

// File: rtl/alu_op_sequencer_alu.sv
// Combinational ALU driven by the sequencer: add, subtract, and, xor.
module alu_op_sequencer_alu
    import alu_op_sequencer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        unique case (sel)
            SEL_0: y = a + b;
            SEL_1: y = a - b;
            SEL_2: y = a & b;
            SEL_3: y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Registers commands onto the ALU inputs, waits a settle time, captures the
// result and returns it over a valid/ready handshake; one command in flight.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [1:0]       cmd_sel,
    input  logic             cmd_chain,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [1:0]       res_sel,
    output logic [CNT_W-1:0] op_count
);

    seq_state_t       state;
    logic [3:0]       settle_cnt;
    logic [WIDTH-1:0] last_result;

    // Decoded from the state register only, so never combinational on cmd_valid.
    assign cmd_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            settle_cnt  <= '0;
            last_result <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_sel     <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_sel     <= '0;
            op_count    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_a      <= cmd_chain ? last_result : cmd_a;
                        alu_b      <= cmd_b;
                        alu_sel    <= cmd_sel;
                        settle_cnt <= 4'(SETTLE_CYCLES - 1);
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    res_data    <= alu_out;
                    res_sel     <= alu_sel;
                    last_result <= alu_out;
                    res_valid   <= 1'b1;
                    state       <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        op_count  <= op_count + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with its ALU; a second narrow-counter instance
// shares the same stimulus so counter wrap is observed alongside.
module tb_alu_op_sequencer;
    import alu_op_sequencer_pkg::*;

    localparam int W = 8;
    localparam int SC = 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready, cmd_ready2;
    logic [W-1:0] cmd_a, cmd_b;
    logic [1:0]   cmd_sel;
    logic         cmd_chain;
    logic [W-1:0] alu_a, alu_b, alu_y, alu_a2, alu_b2, alu_y2;
    logic [1:0]   alu_sel, alu_sel2;
    logic         res_valid, res_valid2;
    logic         res_ready;
    logic [W-1:0] res_data, res_data2;
    logic [1:0]   res_sel, res_sel2;
    logic [15:0]  op_count;
    logic [1:0]   op_count2;

    int n_checks = 0;
    int n_pass   = 0;

    int           m_count;
    logic [W-1:0] m_last;

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(W), .SETTLE_CYCLES(SC), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_chain(cmd_chain),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_y),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_sel(res_sel), .op_count(op_count)
    );

    alu_op_sequencer_alu #(.WIDTH(W)) alu (
        .a(alu_a), .b(alu_b), .sel(alu_sel), .y(alu_y)
    );

    alu_op_sequencer #(.WIDTH(W), .SETTLE_CYCLES(SC), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_chain(cmd_chain),
        .alu_a(alu_a2), .alu_b(alu_b2), .alu_sel(alu_sel2), .alu_out(alu_y2),
        .res_valid(res_valid2), .res_ready(res_ready), .res_data(res_data2),
        .res_sel(res_sel2), .op_count(op_count2)
    );

    alu_op_sequencer_alu #(.WIDTH(W)) alu2 (
        .a(alu_a2), .b(alu_b2), .sel(alu_sel2), .y(alu_y2)
    );

    function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] sel);
        int r;
        case (sel)
            2'd0:    r = int'(a) + int'(b);
            2'd1:    r = int'(a) - int'(b) + 256;
            2'd2:    r = int'(a & b);
            default: r = int'(a ^ b);
        endcase
        return W'(r % 256);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_idle_reset_state();
        check("rst_alu_a", 32'(alu_a), 0);
        check("rst_alu_b", 32'(alu_b), 0);
        check("rst_alu_sel", 32'(alu_sel), 0);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_res_data", 32'(res_data), 0);
        check("rst_res_sel", 32'(res_sel), 0);
        check("rst_op_count", 32'(op_count), 0);
        check("rst_op_count2", 32'(op_count2), 0);
        check("rst_cmd_ready", 32'(cmd_ready), 1);
    endtask

    // Called at a negedge with the sequencer idle; returns at a negedge, idle again.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] sel,
                         input logic chain, input int hold);
        logic [W-1:0] ea;
        logic [W-1:0] er;
        int lat;
        ea = chain ? m_last : a;
        er = ref_alu(ea, b, sel);
        check("cmd_ready_idle", 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_sel   = sel;
        cmd_chain = chain;
        res_ready = (hold == 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_a     = W'($urandom);
        cmd_b     = W'($urandom);
        cmd_sel   = 2'($urandom);
        cmd_chain = 1'($urandom);
        check("alu_a", 32'(alu_a), 32'(ea));
        check("alu_b", 32'(alu_b), 32'(b));
        check("alu_sel", 32'(alu_sel), 32'(sel));
        lat = 1;
        while (!res_valid && lat < 20) begin
            check("cmd_ready_busy", 32'(cmd_ready), 0);
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(SC + 2));
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", 32'(res_valid), 1);
            check("hold_data", 32'(res_data), 32'(er));
            check("hold_cmd_ready", 32'(cmd_ready), 0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        check("res_valid", 32'(res_valid), 1);
        check("res_data", 32'(res_data), 32'(er));
        check("res_sel", 32'(res_sel), 32'(sel));
        check("res_data2", 32'(res_data2), 32'(er));
        @(negedge clk);
        res_ready = 1'b0;
        m_count++;
        m_last = er;
        check("res_valid_drop", 32'(res_valid), 0);
        check("op_count", 32'(op_count), 32'(m_count % 65536));
        check("op_count2", 32'(op_count2), 32'(m_count % 4));
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_sel = '0;
        cmd_chain = 1'b0; res_ready = 1'b0;
        m_count = 0; m_last = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_idle_reset_state();

        // Chain as the very first command: A must be the cleared last result.
        do_op(8'hAA, 8'h15, SEL_0, 1'b1, 0);

        do_op(8'h06, 8'h15, SEL_0, 1'b0, 0);
        do_op(8'h06, 8'h15, SEL_0, 1'b0, 0);
        do_op(8'h06, 8'h15, SEL_1, 1'b0, 0);
        do_op(8'h06, 8'h15, SEL_2, 1'b0, 0);
        do_op(8'h06, 8'h15, SEL_3, 1'b0, 0);

        do_op(8'h3C, 8'h5A, SEL_1, 1'b0, 10);

        do_op(8'h11, 8'h22, SEL_0, 1'b0, 0);
        do_op(8'hFF, 8'h01, SEL_0, 1'b1, 0);

        for (int i = 0; i < 24; i++) begin
            do_op(W'($urandom), W'($urandom), 2'($urandom), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)));
        end

        // Reset held across two edges while an operation is settling.
        cmd_valid = 1'b1; cmd_a = 8'h77; cmd_b = 8'h01; cmd_sel = SEL_0; cmd_chain = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        res_ready = 1'b0;
        m_count = 0; m_last = '0;
        check_idle_reset_state();
        repeat (3) @(negedge clk);
        check("abort_no_result", 32'(res_valid), 0);
        check("abort_no_count", 32'(op_count), 0);

        for (int i = 0; i < 5; i++) begin
            do_op(W'($urandom), W'($urandom), 2'($urandom), 1'b0, 0);
        end
        check("wrap_op_count2", 32'(op_count2), 1);
        check("wrap_op_count", 32'(op_count), 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
